// File: rtl/memory_stage_if.sv
// memory_stage_if: bundles the three handshakes of the Y86-64 memory stage.
//   upstream   : in_valid/in_ready with {icode, valE, valA, valP} from execute
//   downstream : out_valid/out_ready with {icode_out, valE_out, valM, stat} to write-back
//   data memory: mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata/mem_err back
// The slave modport is the stage itself; the master modport is its environment.
interface memory_stage_if #(
    parameter int ADDR_W = 13
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic [63:0]       valE;
    logic [63:0]       valA;
    logic [63:0]       valP;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        icode_out;
    logic [63:0]       valE_out;
    logic [63:0]       valM;
    logic [2:0]        stat;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_ack;
    logic [63:0]       mem_rdata;
    logic              mem_err;

    modport master (
        output in_valid, icode, valE, valA, valP, out_ready, mem_ack, mem_rdata, mem_err,
        input  in_ready, out_valid, icode_out, valE_out, valM, stat,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, icode, valE, valA, valP, out_ready, mem_ack, mem_rdata, mem_err,
        output in_ready, out_valid, icode_out, valE_out, valM, stat,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 memory-access stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : memory_stage_if.slave (upstream, downstream and data-memory handshakes)
// One instruction in flight: IDLE accepts, REQ waits for the memory (bounded by
// TIMEOUT), RESP presents the result until write-back takes it. Any non-AOK
// status halts the stage until reset.
module memory_stage #(
    parameter int MEM_BYTES = 8192,
    parameter int ADDR_W    = 13,
    parameter int TIMEOUT   = 16
) (
    input logic            clk,
    input logic            rst,
    memory_stage_if.slave  bus
);
    localparam int          CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);
    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_HLT = 3'd2;
    localparam logic [2:0]  STAT_ADR = 3'd3;
    localparam logic [2:0]  STAT_INS = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          icode_q, icode_d;
    logic [63:0]         vale_q, vale_d;
    logic [63:0]         valm_q, valm_d;
    logic [2:0]          stat_q, stat_d;
    logic                halted_q, halted_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Instruction decode of the incoming bundle
    logic                dec_acc;
    logic                dec_we;
    logic [63:0]         dec_sel;
    logic [63:0]         dec_wdata;
    logic [2:0]          dec_stat;

    always_comb begin
        dec_acc   = 1'b0;
        dec_we    = 1'b0;
        dec_sel   = bus.valE;
        dec_wdata = bus.valA;
        dec_stat  = STAT_AOK;
        case (bus.icode)
            4'h0:                   dec_stat = STAT_HLT;
            4'h1, 4'h2, 4'h3,
            4'h6, 4'h7:             dec_stat = STAT_AOK;
            4'h4, 4'hA:             begin dec_acc = 1'b1; dec_we = 1'b1; end
            4'h5:                   dec_acc = 1'b1;
            4'h8:                   begin dec_acc = 1'b1; dec_we = 1'b1; dec_wdata = bus.valP; end
            4'h9, 4'hB:             begin dec_acc = 1'b1; dec_sel = bus.valA; end
            default:                dec_stat = STAT_INS;
        endcase
    end

    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        vale_d  = vale_q;
        valm_d  = valm_q;
        stat_d  = stat_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !halted_q) begin
                    icode_d = bus.icode;
                    vale_d  = bus.valE;
                    valm_d  = 64'd0;
                    stat_d  = dec_stat;
                    state_d = S_RESP;
                    if (dec_acc) begin
                        // Full 64-bit range check: high address bits must not alias into memory.
                        if (dec_sel > MAX_ADDR) begin
                            stat_d = STAT_ADR;
                        end else begin
                            state_d = S_REQ;
                            req_d   = 1'b1;
                            we_d    = dec_we;
                            addr_d  = dec_sel[ADDR_W-1:0];
                            wdata_d = dec_wdata;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            S_REQ: begin
                // An ack always wins over the timeout firing in the same cycle.
                if (bus.mem_ack) begin
                    state_d = S_RESP;
                    req_d   = 1'b0;
                    if (bus.mem_err) begin
                        stat_d = STAT_ADR;
                        valm_d = 64'd0;
                    end else begin
                        valm_d = we_q ? 64'd0 : bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = S_RESP;
                        req_d   = 1'b0;
                        stat_d  = STAT_ADR;
                    end
                end
            end
            S_RESP: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        halted_d = halted_q | ((state_q == S_RESP) && (stat_q != STAT_AOK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            icode_q  <= 4'd0;
            vale_q   <= 64'd0;
            valm_q   <= 64'd0;
            stat_q   <= STAT_AOK;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 64'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            icode_q  <= icode_d;
            vale_q   <= vale_d;
            valm_q   <= valm_d;
            stat_q   <= stat_d;
            halted_q <= halted_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !halted_q;
    assign bus.out_valid = (state_q == S_RESP);
    assign bus.icode_out = icode_q;
    assign bus.valE_out  = vale_q;
    assign bus.valM      = valm_q;
    assign bus.stat      = stat_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed instructions with a bench-side response model
// and a per-cycle compare process on the falling edge.
module tb_memory_stage;
    localparam int MEM_BYTES = 8192;
    localparam int ADDR_W    = 13;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_stage_if #(.ADDR_W(ADDR_W)) b();

    memory_stage #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model expectations for the instruction currently in flight
    logic              exp_acc;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [63:0]       exp_wdata;
    logic [2:0]        exp_stat;
    logic [63:0]       exp_valm;
    logic [3:0]        exp_ic;
    logic [63:0]       exp_e;
    int                exp_reqn;
    int                exp_lat;
    logic [2:0]        o_stat;
    logic [63:0]       o_valm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Response model from the instruction semantics: which access, what status,
    // how many request cycles and how long until the result appears.
    task automatic model(input logic [3:0] ic, input logic [63:0] e, a, p,
                         input int dly, input logic er, input logic [63:0] rd);
        logic [63:0] sel;
        exp_ic = ic; exp_e = e;
        exp_acc = 0; exp_we = 0; sel = e; exp_wdata = a;
        exp_stat = 3'd1; exp_valm = 0; exp_reqn = 0;
        if (ic == 0) exp_stat = 3'd2;
        else if (ic == 4 || ic == 10) begin exp_acc = 1; exp_we = 1; end
        else if (ic == 5) exp_acc = 1;
        else if (ic == 8) begin exp_acc = 1; exp_we = 1; exp_wdata = p; end
        else if (ic == 9 || ic == 11) begin exp_acc = 1; sel = a; end
        else if (ic > 11) exp_stat = 3'd4;
        if (exp_acc && sel > 64'(MEM_BYTES - 8)) begin
            exp_acc = 0; exp_stat = 3'd3;
        end
        if (exp_acc) begin
            if (dly < 0 || dly >= TIMEOUT) begin
                exp_reqn = TIMEOUT; exp_stat = 3'd3;
            end else begin
                exp_reqn = dly + 1;
                if (er) exp_stat = 3'd3;
                else if (!exp_we) exp_valm = rd;
            end
        end
        exp_addr = sel[ADDR_W-1:0];
        exp_lat  = exp_reqn + 1;
    endtask

    // Per-cycle comparison of the DUT outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (b.mem_req) begin
                chk("req_allowed", b.mem_req, exp_acc);
                chk("mem_we", b.mem_we, exp_we);
                chk("mem_addr", b.mem_addr, exp_addr);
                chk("mem_wdata", b.mem_wdata, exp_wdata);
            end
            if (b.out_valid) begin
                chk("stat", b.stat, exp_stat);
                chk("valM", b.valM, exp_valm);
                chk("icode_out", b.icode_out, exp_ic);
                chk("valE_out", b.valE_out, exp_e);
            end
        end
    end

    task automatic reset_dut();
        rst = 1;
        b.in_valid = 0; b.icode = 0; b.valE = 0; b.valA = 0; b.valP = 0;
        b.out_ready = 0; b.mem_ack = 0; b.mem_rdata = 0; b.mem_err = 0;
        exp_acc = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    // Issue one instruction, play the memory (ack on request cycle index dly,
    // -1 = never), then hold the result for `hold` cycles before accepting it.
    task automatic run(input string nm, input logic [3:0] ic, input logic [63:0] e, a, p,
                       input int dly, input logic er, input logic [63:0] rd, input int hold);
        int rq;
        int lat;
        model(ic, e, a, p, dly, er, rd);
        b.icode = ic; b.valE = e; b.valA = a; b.valP = p; b.in_valid = 1;
        chk({nm, "_in_ready"}, b.in_ready, 1);
        @(posedge clk); #1;
        b.in_valid = 0;
        rq = 0; lat = 1;
        while (!b.out_valid && lat < 64) begin
            if (b.mem_req) begin
                b.mem_ack = (rq == dly);
                b.mem_err = er && (rq == dly);
                b.mem_rdata = rd;
                rq++;
            end
            @(posedge clk); #1;
            b.mem_ack = 0; b.mem_err = 0;
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_req_cycles"}, rq, exp_reqn);
        o_stat = b.stat; o_valm = b.valM;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_held_valid"}, b.out_valid, 1);
        b.out_ready = 1;
        @(posedge clk); #1;
        b.out_ready = 0;
        chk({nm, "_released"}, b.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        chk("rst_in_ready", b.in_ready, 1);
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_mem_req", b.mem_req, 0);
        chk("rst_mem_we", b.mem_we, 0);
        chk("rst_mem_addr", b.mem_addr, 0);
        chk("rst_mem_wdata", b.mem_wdata, 0);
        chk("rst_valM", b.valM, 0);
        chk("rst_valE_out", b.valE_out, 0);
        chk("rst_icode_out", b.icode_out, 0);
        chk("rst_stat", b.stat, 1);

        // mrmovq, ack on third request cycle
        run("mrmovq", 4'h5, 64'h100, 64'h0, 64'h0, 2, 0, 64'hDEADBEEF, 2);
        chk("mrmovq_valM_lit", o_valm, 64'hDEADBEEF);
        chk("mrmovq_stat_lit", o_stat, 1);
        chk("mrmovq_reqn_lit", exp_reqn, 3);

        // pushq zero-wait write at top of memory
        run("pushq", 4'hA, 64'h1FF8, 64'h55, 64'h0, 0, 0, 64'h0, 0);
        chk("pushq_lat_lit", exp_lat, 2);
        // other access kinds
        run("rmmovq", 4'h4, 64'h0, 64'h1234, 64'h0, 1, 0, 64'h0, 0);
        run("call", 4'h8, 64'h1F0, 64'h0, 64'hABCD, 0, 0, 64'h0, 0);
        run("popq", 4'hB, 64'h48, 64'h40, 64'h0, 3, 0, 64'h77, 1);
        run("ret", 4'h9, 64'h50, 64'h1FF8, 64'h0, 15, 0, 64'h900, 0);
        chk("ret_late_ack_stat", o_stat, 1);
        run("irmovq", 4'h3, 64'h99, 64'h0, 64'h0, 0, 0, 64'h0, 0);
        chk("after_aok_in_ready", b.in_ready, 1);

        // memory error on ack
        run("mrmovq_err", 4'h5, 64'h10, 64'h0, 64'h0, 1, 1, 64'hFFFF, 0);
        chk("err_stat_lit", o_stat, 3);
        chk("err_valM_lit", o_valm, 0);
        reset_dut();

        // out-of-range address: no request, sticky fault, no further accept
        run("rmmovq_oob", 4'h4, 64'h1FF9, 64'h1, 64'h0, 0, 0, 64'h0, 0);
        chk("oob_stat_lit", o_stat, 3);
        b.icode = 4'h5; b.valE = 64'h8; b.in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("halted_in_ready", b.in_ready, 0);
            @(posedge clk); #1;
            chk("halted_no_out", b.out_valid, 0);
            chk("halted_no_req", b.mem_req, 0);
        end
        b.in_valid = 0;
        chk("sticky_stat", b.stat, 3);
        reset_dut();

        // high address bits must not alias into memory
        run("mrmovq_hi", 4'h5, 64'h0001_0000_0000_0100, 64'h0, 64'h0, 0, 0, 64'h0, 0);
        reset_dut();

        // timeout with no ack, then ack exactly at the last allowed cycle
        run("timeout", 4'h5, 64'h20, 64'h0, 64'h0, -1, 0, 64'h0, 0);
        chk("timeout_stat_lit", o_stat, 3);
        reset_dut();
        run("ack_at_16", 4'h5, 64'h28, 64'h0, 64'h0, 15, 0, 64'h5A5A, 0);
        chk("ack16_stat_lit", o_stat, 1);
        reset_dut();

        // addq then halt, both held 5 cycles
        run("addq", 4'h6, 64'h7, 64'h0, 64'h0, 0, 0, 64'h0, 5);
        chk("addq_stat_lit", o_stat, 1);
        run("halt", 4'h0, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 5);
        chk("halt_stat_lit", o_stat, 2);
        for (int i = 0; i < 3; i++) begin
            chk("halt_in_ready", b.in_ready, 0);
            @(posedge clk); #1;
        end
        reset_dut();

        // undefined opcode
        run("ins", 4'hC, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0);
        chk("ins_stat_lit", o_stat, 4);
        reset_dut();

        // reset during REQ, then a late ack in IDLE
        model(4'h5, 64'h200, 64'h0, 64'h0, -1, 0, 64'h0);
        b.icode = 4'h5; b.valE = 64'h200; b.in_valid = 1;
        @(posedge clk); #1;
        b.in_valid = 0;
        chk("midreq_req_on", b.mem_req, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midreq_req_off", b.mem_req, 0);
        chk("midreq_stat", b.stat, 1);
        chk("midreq_in_ready", b.in_ready, 1);
        b.mem_ack = 1; b.mem_rdata = 64'h1;
        @(posedge clk); #1;
        b.mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_no_out", b.out_valid, 0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
